// File: rtl/lfu_pkg.sv
// Shared types and helpers for the LFU residency controller.
package lfu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lfu_victim_scan.sv
// Sequential minimum search over the slot use counters; ties keep the lower slot.
module lfu_victim_scan
  import lfu_pkg::*;
#(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned SLOT_W = idx_w(N_SLOTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     abort_i,
  input  logic                     start_i,
  input  logic [N_SLOTS*CNT_W-1:0] cnt_i,
  output logic                     done_o,
  output logic [SLOT_W-1:0]        victim_o
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic [SLOT_W-1:0] victim_q, victim_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0]  cur_cnt;

  always_comb cur_cnt = cnt_i[int'(idx_q)*CNT_W +: CNT_W];

  // Slot 0 seeds the minimum on the start edge; later slots follow one per cycle.
  always_comb begin
    busy_d   = busy_q;
    idx_d    = idx_q;
    victim_d = victim_q;
    min_d    = min_q;
    done_d   = 1'b0;
    if (abort_i) begin
      busy_d = 1'b0;
      idx_d  = '0;
    end else if (start_i) begin
      min_d    = cnt_i[CNT_W-1:0];
      victim_d = '0;
      idx_d    = SLOT_W'(1);
      busy_d   = (N_SLOTS > 1);
      done_d   = (N_SLOTS == 1);
    end else if (busy_q) begin
      if (cur_cnt < min_q) begin
        min_d    = cur_cnt;
        victim_d = idx_q;
      end
      if (idx_q == LAST_SLOT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      victim_q <= '0;
      min_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      min_q    <= min_d;
    end
  end

  assign done_o   = done_q;
  assign victim_o = victim_q;

endmodule

// File: rtl/lfu_cache_ctrl.sv
// LFU residency controller: slot array, request FSM, hit/miss/evict reporting and aging.
module lfu_cache_ctrl
  import lfu_pkg::*;
#(
  parameter int unsigned N_ITEMS    = 5,
  parameter int unsigned N_SLOTS    = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned AGE_PERIOD = 0,
  localparam int unsigned IDX_W     = idx_w(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               req_valid_i,
  input  logic [IDX_W-1:0]   req_item_i,
  output logic               req_ready_o,
  output logic               rsp_valid_o,
  output logic               rsp_hit_o,
  output logic               rsp_err_o,
  output logic               rsp_evict_valid_o,
  output logic [IDX_W-1:0]   rsp_evict_item_o,
  output logic [N_ITEMS-1:0] resident_o
);

  localparam int unsigned     SLOT_W  = idx_w(N_SLOTS);
  localparam int unsigned     AGE_W   = idx_w(AGE_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  logic [IDX_W-1:0]   tag_q [N_SLOTS];
  logic [IDX_W-1:0]   tag_d [N_SLOTS];
  logic [CNT_W-1:0]   cnt_q [N_SLOTS];
  logic [CNT_W-1:0]   cnt_d [N_SLOTS];
  logic [N_SLOTS-1:0] valid_q, valid_d;
  logic [AGE_W-1:0]   age_q, age_d;

  logic [IDX_W-1:0]  item_q, item_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              hit_q, hit_d, free_q, free_d, err_q, err_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_ev_valid_q, rsp_ev_valid_d;
  logic [IDX_W-1:0]   rsp_ev_item_q, rsp_ev_item_d;
  logic [N_ITEMS-1:0] resident_q, resident_d;

  logic                     look_hit, look_free, req_err, scan_start, scan_done;
  logic [SLOT_W-1:0]        hit_slot, free_slot, scan_victim, tgt;
  logic [N_SLOTS*CNT_W-1:0] cnt_flat;

  assign req_ready_o = (state_q == IDLE) && !clear_i;
  assign req_err     = 32'(req_item_i) >= N_ITEMS;

  // Tag match and lowest free slot for the incoming request.
  always_comb begin
    look_hit  = 1'b0;
    look_free = 1'b0;
    hit_slot  = '0;
    free_slot = '0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_item_i)) begin
        look_hit = 1'b1;
        hit_slot = SLOT_W'(i);
      end
      if (!valid_q[i]) begin
        look_free = 1'b1;
        free_slot = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  lfu_victim_scan #(
    .N_SLOTS (N_SLOTS),
    .CNT_W   (CNT_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .abort_i  (clear_i),
    .start_i  (scan_start),
    .cnt_i    (cnt_flat),
    .done_o   (scan_done),
    .victim_o (scan_victim)
  );

  always_comb begin
    state_d        = state_q;
    tag_d          = tag_q;
    cnt_d          = cnt_q;
    valid_d        = valid_q;
    age_d          = age_q;
    item_d         = item_q;
    slot_d         = slot_q;
    hit_d          = hit_q;
    free_d         = free_q;
    err_d          = err_q;
    rsp_valid_d    = 1'b0;
    rsp_hit_d      = 1'b0;
    rsp_err_d      = 1'b0;
    rsp_ev_valid_d = 1'b0;
    rsp_ev_item_d  = '0;
    resident_d     = resident_q;
    scan_start     = 1'b0;
    tgt            = '0;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          item_d = req_item_i;
          err_d  = req_err;
          hit_d  = look_hit;
          free_d = look_free;
          slot_d = look_hit ? hit_slot : free_slot;
          if (!req_err && !look_hit && !look_free) begin
            state_d    = SCAN;
            scan_start = 1'b1;
          end else begin
            state_d = COMMIT;
          end
        end
      end
      SCAN: begin
        if (scan_done) state_d = COMMIT;
      end
      COMMIT: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        if (err_q) begin
          rsp_err_d = 1'b1;
        end else begin
          tgt = (hit_q || free_q) ? slot_q : scan_victim;
          if (hit_q) begin
            rsp_hit_d = 1'b1;
            if (cnt_q[tgt] != CNT_MAX) cnt_d[tgt] = cnt_q[tgt] + CNT_W'(1);
          end else begin
            if (!free_q) begin
              rsp_ev_valid_d = 1'b1;
              rsp_ev_item_d  = tag_q[tgt];
            end
            tag_d[tgt]   = item_q;
            valid_d[tgt] = 1'b1;
            cnt_d[tgt]   = CNT_W'(1);
          end
          // Aging halves counters after this request's own update has landed.
          if (AGE_PERIOD != 0) begin
            if (age_q == AGE_W'(AGE_PERIOD - 1)) begin
              age_d = '0;
              for (int i = 0; i < int'(N_SLOTS); i++) cnt_d[i] = cnt_d[i] >> 1;
            end else begin
              age_d = age_q + AGE_W'(1);
            end
          end
          resident_d = '0;
          for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (valid_d[i]) resident_d[tag_d[i]] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d        = IDLE;
      tag_d          = '{default: '0};
      cnt_d          = '{default: '0};
      valid_d        = '0;
      age_d          = '0;
      item_d         = '0;
      slot_d         = '0;
      hit_d          = 1'b0;
      free_d         = 1'b0;
      err_d          = 1'b0;
      rsp_valid_d    = 1'b0;
      rsp_hit_d      = 1'b0;
      rsp_err_d      = 1'b0;
      rsp_ev_valid_d = 1'b0;
      rsp_ev_item_d  = '0;
      resident_d     = '0;
      scan_start     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tag_q          <= '{default: '0};
      cnt_q          <= '{default: '0};
      valid_q        <= '0;
      age_q          <= '0;
      item_q         <= '0;
      slot_q         <= '0;
      hit_q          <= 1'b0;
      free_q         <= 1'b0;
      err_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_hit_q      <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_ev_valid_q <= 1'b0;
      rsp_ev_item_q  <= '0;
      resident_q     <= '0;
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      cnt_q          <= cnt_d;
      valid_q        <= valid_d;
      age_q          <= age_d;
      item_q         <= item_d;
      slot_q         <= slot_d;
      hit_q          <= hit_d;
      free_q         <= free_d;
      err_q          <= err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_hit_q      <= rsp_hit_d;
      rsp_err_q      <= rsp_err_d;
      rsp_ev_valid_q <= rsp_ev_valid_d;
      rsp_ev_item_q  <= rsp_ev_item_d;
      resident_q     <= resident_d;
    end
  end

  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_hit_o         = rsp_hit_q;
  assign rsp_err_o         = rsp_err_q;
  assign rsp_evict_valid_o = rsp_ev_valid_q;
  assign rsp_evict_item_o  = rsp_ev_item_q;
  assign resident_o        = resident_q;

endmodule

// File: tb/tb_lfu_cache_ctrl.sv
// Directed bench for lfu_cache_ctrl: default, CNT_W=2 and AGE_PERIOD=4 instances.
module tb_lfu_cache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      req_valid, clear, req_ready, rsp_valid, rsp_hit, rsp_err, ev_valid;
  logic [2:0][2:0] req_item, ev_item;
  logic [2:0][4:0] resident;

  int checks = 0;
  int errors = 0;

  lfu_cache_ctrl dut0 (
    .clk(clk), .rst(rst), .clear_i(clear[0]), .req_valid_i(req_valid[0]),
    .req_item_i(req_item[0]), .req_ready_o(req_ready[0]), .rsp_valid_o(rsp_valid[0]),
    .rsp_hit_o(rsp_hit[0]), .rsp_err_o(rsp_err[0]), .rsp_evict_valid_o(ev_valid[0]),
    .rsp_evict_item_o(ev_item[0]), .resident_o(resident[0])
  );

  lfu_cache_ctrl #(.CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .clear_i(clear[1]), .req_valid_i(req_valid[1]),
    .req_item_i(req_item[1]), .req_ready_o(req_ready[1]), .rsp_valid_o(rsp_valid[1]),
    .rsp_hit_o(rsp_hit[1]), .rsp_err_o(rsp_err[1]), .rsp_evict_valid_o(ev_valid[1]),
    .rsp_evict_item_o(ev_item[1]), .resident_o(resident[1])
  );

  lfu_cache_ctrl #(.AGE_PERIOD(4)) dut2 (
    .clk(clk), .rst(rst), .clear_i(clear[2]), .req_valid_i(req_valid[2]),
    .req_item_i(req_item[2]), .req_ready_o(req_ready[2]), .rsp_valid_o(rsp_valid[2]),
    .rsp_hit_o(rsp_hit[2]), .rsp_err_o(rsp_err[2]), .rsp_evict_valid_o(ev_valid[2]),
    .rsp_evict_item_o(ev_item[2]), .resident_o(resident[2])
  );

  // Issue one request on instance d and collect its response; lat = 99 if none arrives.
  task automatic do_req(input int d, input logic [2:0] item, output int lat,
                        output logic hit, output logic err, output logic evv,
                        output logic [2:0] evi, output logic [4:0] res);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_item[d]  = item;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 99; hit = 1'b0; err = 1'b0; evv = 1'b0; evi = '0; res = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[d]) begin
        lat = c; hit = rsp_hit[d]; err = rsp_err[d];
        evv = ev_valid[d]; evi = ev_item[d]; res = resident[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready[0]); end
    checks++;
    if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", rsp_valid); end
    checks++;
    if (resident[0] !== 5'b00000) begin errors++; $display("FAIL reset_resident: got %b expected 00000", resident[0]); end
    checks++;
    if (ev_valid[0] !== 1'b0 || ev_item[0] !== 3'd0) begin
      errors++; $display("FAIL reset_evict: got %b/%0d expected 0/0", ev_valid[0], ev_item[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_evict();
    int         items [11] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3};
    logic       exp_h [11] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    int         lat;
    logic       hit, err, evv;
    logic [2:0] evi;
    logic [4:0] res;
    for (int i = 0; i < 11; i++) begin
      do_req(0, 3'(items[i]), lat, hit, err, evv, evi, res);
      checks++;
      if (lat !== 1 || hit !== exp_h[i] || evv !== 1'b0) begin
        errors++;
        $display("FAIL fill_req%0d: got lat=%0d hit=%b ev=%b expected lat=1 hit=%b ev=0",
                 i, lat, hit, evv, exp_h[i]);
      end
    end
    checks++;
    if (res !== 5'b01111) begin errors++; $display("FAIL fill_resident: got %b expected 01111", res); end
    do_req(0, 3'd4, lat, hit, err, evv, evi, res);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL evict_latency: got %0d expected 5", lat); end
    checks++;
    if (hit !== 1'b0 || evv !== 1'b1 || evi !== 3'd3) begin
      errors++; $display("FAIL evict_victim: got hit=%b ev=%b item=%0d expected 0/1/3", hit, evv, evi);
    end
    checks++;
    if (res !== 5'b10111) begin errors++; $display("FAIL evict_resident: got %b expected 10111", res); end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || ev_valid[0] !== 1'b0) begin
      errors++; $display("FAIL rsp_pulse: got valid=%b ev=%b expected 0/0", rsp_valid[0], ev_valid[0]);
    end
  endtask

  task automatic test_tie();
    int         lat;
    logic       hit, err, evv;
    logic [2:0] evi;
    logic [4:0] res;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) do_req(0, 3'(i), lat, hit, err, evv, evi, res);
    do_req(0, 3'd4, lat, hit, err, evv, evi, res);
    checks++;
    if (lat !== 5 || evv !== 1'b1 || evi !== 3'd0) begin
      errors++; $display("FAIL tie_victim: got lat=%0d ev=%b item=%0d expected 5/1/0", lat, evv, evi);
    end
    checks++;
    if (res !== 5'b11110) begin errors++; $display("FAIL tie_resident: got %b expected 11110", res); end
  endtask

  task automatic test_saturate();
    int         lat;
    logic       hit, err, evv;
    logic [2:0] evi;
    logic [4:0] res;
    for (int i = 0; i < 5; i++) do_req(1, 3'd0, lat, hit, err, evv, evi, res);
    checks++;
    if (hit !== 1'b1 || lat !== 1) begin errors++; $display("FAIL sat_hit: got hit=%b lat=%0d expected 1/1", hit, lat); end
    for (int it = 1; it <= 3; it++)
      for (int k = 0; k < 3; k++) do_req(1, 3'(it), lat, hit, err, evv, evi, res);
    do_req(1, 3'd4, lat, hit, err, evv, evi, res);
    checks++;
    if (lat !== 5 || evv !== 1'b1 || evi !== 3'd0) begin
      errors++; $display("FAIL sat_victim: got lat=%0d ev=%b item=%0d expected 5/1/0", lat, evv, evi);
    end
    checks++;
    if (res !== 5'b11110) begin errors++; $display("FAIL sat_resident: got %b expected 11110", res); end
  endtask

  task automatic test_aging();
    int         lat;
    logic       hit, err, evv;
    logic [2:0] evi;
    logic [4:0] res;
    for (int i = 0; i < 4; i++) do_req(2, 3'd0, lat, hit, err, evv, evi, res);
    for (int i = 0; i < 3; i++) do_req(2, 3'd1, lat, hit, err, evv, evi, res);
    do_req(2, 3'd2, lat, hit, err, evv, evi, res);
    do_req(2, 3'd3, lat, hit, err, evv, evi, res);
    checks++;
    if (res !== 5'b01111) begin errors++; $display("FAIL age_resident: got %b expected 01111", res); end
    do_req(2, 3'd4, lat, hit, err, evv, evi, res);
    checks++;
    if (lat !== 5 || evv !== 1'b1 || evi !== 3'd2) begin
      errors++; $display("FAIL age_victim: got lat=%0d ev=%b item=%0d expected 5/1/2", lat, evv, evi);
    end
    checks++;
    if (res !== 5'b11011) begin errors++; $display("FAIL age_resident2: got %b expected 11011", res); end
    // All four counters now equal 1, so the lowest slot (item 0) goes.
    do_req(2, 3'd2, lat, hit, err, evv, evi, res);
    checks++;
    if (evv !== 1'b1 || evi !== 3'd0 || res !== 5'b11110) begin
      errors++; $display("FAIL age_victim2: got ev=%b item=%0d res=%b expected 1/0/11110", evv, evi, res);
    end
  endtask

  task automatic test_error_clear();
    int         lat;
    int         seen;
    logic       hit, err, evv;
    logic [2:0] evi;
    logic [4:0] res;
    do_req(0, 3'd7, lat, hit, err, evv, evi, res);
    checks++;
    if (lat !== 1 || err !== 1'b1 || hit !== 1'b0 || evv !== 1'b0) begin
      errors++; $display("FAIL err_rsp: got lat=%0d err=%b hit=%b ev=%b expected 1/1/0/0", lat, err, hit, evv);
    end
    checks++;
    if (res !== 5'b11110) begin errors++; $display("FAIL err_resident: got %b expected 11110", res); end
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_item[0]  = 3'd0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL scan_ready: got %b expected 0", req_ready[0]); end
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL clear_no_rsp: got %0d responses expected 0", seen); end
    checks++;
    if (resident[0] !== 5'b00000 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL clear_state: got res=%b ready=%b expected 00000/1", resident[0], req_ready[0]);
    end
  endtask

  task automatic test_rst_scan();
    int         lat;
    int         seen;
    logic       hit, err, evv;
    logic [2:0] evi;
    logic [4:0] res;
    for (int i = 0; i < 4; i++) do_req(0, 3'(i), lat, hit, err, evv, evi, res);
    checks++;
    if (res !== 5'b01111) begin errors++; $display("FAIL rst_pre_resident: got %b expected 01111", res); end
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_item[0]  = 3'd4;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (resident[0] !== 5'b00000 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_scan: got res=%b valid=%b ready=%b expected 00000/0/1",
               resident[0], rsp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_no_rsp: got %0d responses expected 0", seen); end
  endtask

  initial begin
    req_valid = '0;
    clear     = '0;
    req_item  = '0;
    test_reset();
    test_fill_evict();
    test_tie();
    test_saturate();
    test_aging();
    test_error_clear();
    test_rst_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
